btn_pulse_cond: RTL

//   Conditions raw push-button/switch inputs into clean one-cycle enable pulses.

---
 rtl/btn_pulse_cond_if.sv | 20 ++
 rtl/btn_pulse_cond.sv | 129 ++++++++++++
 2 files changed

// File: rtl/btn_pulse_cond_if.sv
// Button conditioner bus: raw button levels in, press pulses and debounced levels out.
interface btn_pulse_cond_if #(
    parameter int N = 2
);
    logic [N-1:0] btn_in;
    logic [N-1:0] pulse_out;
    logic [N-1:0] level_out;

    modport master (
        output btn_in,
        input  pulse_out,
        input  level_out
    );

    modport slave (
        input  btn_in,
        output pulse_out,
        output level_out
    );
endinterface

// File: rtl/btn_pulse_cond.sv
// Per-channel button conditioner: 2-flop synchroniser, debounce FSM, registered
// one-cycle press pulse and optional auto-repeat while the button is held.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | button released and stable; waiting for synchronised high
// PRESS_CHK   | input high, counting stable cycles before accepting press
// HELD        | press accepted; level high; auto-repeat counting if enabled
// RELEASE_CHK | input low, counting stable cycles before accepting release
module btn_pulse_cond #(
    parameter int N             = 2,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_CYCLES = 0,
    parameter int CNT_W         = 20
) (
    input logic                  clk,
    input logic                  rst,
    btn_pulse_cond_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    // Only meaningful when auto-repeat is enabled; guarded where used.
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [N-1:0] s1_q;
    logic [N-1:0] s2_q;

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus.btn_in;
            s2_q <= s1_q;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        state_t           state_q, state_nxt;
        logic [CNT_W-1:0] cnt_q, cnt_nxt;
        logic [CNT_W-1:0] rcnt_q, rcnt_nxt;
        logic             pulse_q, pulse_nxt;
        logic             level_c;

        // State, counters and the press pulse are all registered together.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                rcnt_q  <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_nxt;
                cnt_q   <= cnt_nxt;
                rcnt_q  <= rcnt_nxt;
                pulse_q <= pulse_nxt;
            end
        end

        // Debounce transitions, counter updates and pulse events.
        always_comb begin
            state_nxt = state_q;
            cnt_nxt   = cnt_q;
            rcnt_nxt  = rcnt_q;
            pulse_nxt = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (s2_q[g]) begin
                        state_nxt = ST_PRESS_CHK;
                        cnt_nxt   = '0;
                    end
                end
                ST_PRESS_CHK: begin
                    if (!s2_q[g]) begin
                        state_nxt = ST_IDLE;
                    end else if (cnt_q == DB_LAST) begin
                        state_nxt = ST_HELD;
                        rcnt_nxt  = '0;
                        pulse_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!s2_q[g]) begin
                        state_nxt = ST_RELEASE_CHK;
                        cnt_nxt   = '0;
                    end else if (REPEAT_CYCLES > 0) begin
                        if (rcnt_q == RP_LAST) begin
                            pulse_nxt = 1'b1;
                            rcnt_nxt  = '0;
                        end else begin
                            rcnt_nxt = rcnt_q + 1'b1;
                        end
                    end
                    // With repeat disabled rcnt is left at zero so it can never wrap.
                end
                ST_RELEASE_CHK: begin
                    if (s2_q[g]) begin
                        state_nxt = ST_HELD;
                        rcnt_nxt  = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        // Debounced level follows the registered state.
        always_comb begin
            level_c = (state_q == ST_HELD) || (state_q == ST_RELEASE_CHK);
        end

        assign bus.level_out[g] = level_c;
        assign bus.pulse_out[g] = pulse_q;
    end

endmodule
